count_checker: RTL and testbench

//  Downstream monitor for the 2-bit free-running counter (count_o). Samples the count

---
 rtl/count_checker.sv | 183 ++++++++++++++++++
 tb/tb_count_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// ============================================================================
// count_checker : step monitor for a 2-bit free-running counter; locks after
//                 LOCK_CYCLES good +1 steps, flags/counts bad steps and wraps.
// Optional: COUNT_CHECKER_CAPTURE_EN adds first-error capture outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_checker #(
    parameter int LOCK_CYCLES = 4,
    parameter int WRAP_W      = 8,
    parameter int ERR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        count_i,
    input  logic              clr_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_count_o,
    output logic [WRAP_W-1:0] wrap_count_o
`ifdef COUNT_CHECKER_CAPTURE_EN
    ,
    output logic              cap_valid_o,
    output logic [1:0]        cap_exp_o,
    output logic [1:0]        cap_act_o
`endif
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [4:0]        c_LOCK_CYCLES = 5'(LOCK_CYCLES);
    localparam logic [ERR_W-1:0]  c_ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [WRAP_W-1:0] c_WRAP_MAX    = {WRAP_W{1'b1}};

    state_t            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic              primed_q, primed_d;
    logic [3:0]        run_q, run_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [1:0]        w_exp;
    logic              w_good;
    logic              w_wrap_step;
    logic [4:0]        w_run_inc;

    assign w_exp       = prev_q + 2'd1;
    assign w_good      = primed_q && (count_i == w_exp);
    assign w_wrap_step = w_good && (prev_q == 2'd3);
    assign w_run_inc   = {1'b0, run_q} + 5'd1;

`ifdef COUNT_CHECKER_CAPTURE_EN
    logic       cap_valid_q, cap_valid_d;
    logic [1:0] cap_exp_q, cap_exp_d;
    logic [1:0] cap_act_q, cap_act_d;
`endif

    always_comb begin
        state_d    = state_q;
        prev_d     = count_i;
        primed_d   = 1'b1;
        run_d      = run_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
`ifdef COUNT_CHECKER_CAPTURE_EN
        cap_valid_d = cap_valid_q;
        cap_exp_d   = cap_exp_q;
        cap_act_d   = cap_act_q;
`endif

        case (state_q)
            ST_UNLOCKED: begin
                if (w_good) begin
                    if (w_run_inc == c_LOCK_CYCLES) begin
                        state_d = ST_LOCKED;
                        run_d   = 4'd0;
                    end else begin
                        run_d = w_run_inc[3:0];
                    end
                end else begin
                    run_d = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (w_good) begin
                    if (w_wrap_step && (wrap_cnt_q != c_WRAP_MAX)) begin
                        wrap_cnt_d = wrap_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    if (err_cnt_q != c_ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
`ifdef COUNT_CHECKER_CAPTURE_EN
                    if (!cap_valid_q) begin
                        cap_valid_d = 1'b1;
                        cap_exp_d   = w_exp;
                        cap_act_d   = count_i;
                    end
`endif
                end
            end
            // The step seen while in FAULT is deliberately ignored.
            ST_FAULT: begin
                state_d = ST_UNLOCKED;
                run_d   = 4'd0;
            end
            default: begin
                state_d = ST_UNLOCKED;
                run_d   = 4'd0;
            end
        endcase

        if (clr_i) begin
            state_d    = ST_UNLOCKED;
            prev_d     = 2'd0;
            primed_d   = 1'b0;
            run_d      = 4'd0;
            err_d      = 1'b0;
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
`ifdef COUNT_CHECKER_CAPTURE_EN
            cap_valid_d = 1'b0;
            cap_exp_d   = 2'd0;
            cap_act_d   = 2'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNLOCKED;
            prev_q     <= 2'd0;
            primed_q   <= 1'b0;
            run_q      <= 4'd0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            run_q      <= run_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

`ifdef COUNT_CHECKER_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_exp_q   <= 2'd0;
            cap_act_q   <= 2'd0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_exp_q   <= cap_exp_d;
            cap_act_q   <= cap_act_d;
        end
    end

    assign cap_valid_o = cap_valid_q;
    assign cap_exp_o   = cap_exp_q;
    assign cap_act_o   = cap_act_q;
`endif

    assign locked_o     = (state_q == ST_LOCKED);
    assign err_o        = err_q;
    assign err_count_o  = err_cnt_q;
    assign wrap_count_o = wrap_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_count_checker.sv
// ============================================================================
// tb_count_checker : directed self-checking bench for count_checker, with a
//                    second instance (ERR_W=2, WRAP_W=2) for saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_count_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] count_i;
    logic       clr_i;

    logic       locked_o,  err_o;
    logic [3:0] err_count_o;
    logic [7:0] wrap_count_o;
    logic       s_locked_o, s_err_o;
    logic [1:0] s_err_count_o;
    logic [1:0] s_wrap_count_o;
`ifdef COUNT_CHECKER_CAPTURE_EN
    logic       cap_valid_o,   s_cap_valid_o;
    logic [1:0] cap_exp_o,     s_cap_exp_o;
    logic [1:0] cap_act_o,     s_cap_act_o;
`endif

    int errors = 0;
    int checks = 0;
    logic [1:0] cur;
    logic       seen_err;

    count_checker #(.LOCK_CYCLES(4), .WRAP_W(8), .ERR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_i      (count_i),
        .clr_i        (clr_i),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .err_count_o  (err_count_o),
        .wrap_count_o (wrap_count_o)
`ifdef COUNT_CHECKER_CAPTURE_EN
        ,
        .cap_valid_o  (cap_valid_o),
        .cap_exp_o    (cap_exp_o),
        .cap_act_o    (cap_act_o)
`endif
    );

    count_checker #(.LOCK_CYCLES(4), .WRAP_W(2), .ERR_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_i      (count_i),
        .clr_i        (clr_i),
        .locked_o     (s_locked_o),
        .err_o        (s_err_o),
        .err_count_o  (s_err_count_o),
        .wrap_count_o (s_wrap_count_o)
`ifdef COUNT_CHECKER_CAPTURE_EN
        ,
        .cap_valid_o  (s_cap_valid_o),
        .cap_exp_o    (s_cap_exp_o),
        .cap_act_o    (s_cap_act_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one sample, let one posedge pass, return 1 time unit after it.
    task automatic tick(input logic [1:0] c, input logic clr);
        count_i = c;
        clr_i   = clr;
        cur     = c;
        @(posedge clk);
        #1;
        clr_i   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        count_i  = 2'd0;
        clr_i    = 1'b0;
        cur      = 2'd0;
        seen_err = 1'b0;
        #1;
        check("reset_locked", {31'd0, locked_o}, 32'd0);
        check("reset_err",    {31'd0, err_o}, 32'd0);
        check("reset_errcnt", {28'd0, err_count_o}, 32'd0);
        check("reset_wrap",   {24'd0, wrap_count_o}, 32'd0);

        // Real counter: prime + 4 good steps -> lock after 5th posedge.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick(2'((k - 1) % 4), 1'b0);
            seen_err = seen_err | err_o;
            if (k == 4) check("lock_not_yet", {31'd0, locked_o}, 32'd0);
            if (k == 5) check("lock_5th_edge", {31'd0, locked_o}, 32'd1);
            if (k == 20) check("wrap_after20", {24'd0, wrap_count_o}, 32'd3);
        end
        check("no_err_clean_run", {31'd0, seen_err}, 32'd0);
        check("wrap_16_steps",    {24'd0, wrap_count_o}, 32'd4);
        check("wrap_saturate",    {30'd0, s_wrap_count_o}, 32'd3);

        // Forced jump 1->3 while locked.
        tick(2'd1, 1'b0);
        tick(2'd3, 1'b0);
        check("err_pulse",        {31'd0, err_o}, 32'd1);
        check("errcnt_1",         {28'd0, err_count_o}, 32'd1);
        check("unlocked_on_err",  {31'd0, locked_o}, 32'd0);
`ifdef COUNT_CHECKER_CAPTURE_EN
        check("cap_valid",        {31'd0, cap_valid_o}, 32'd1);
        check("cap_exp",          {30'd0, cap_exp_o}, 32'd2);
        check("cap_act",          {30'd0, cap_act_o}, 32'd3);
`endif
        tick(2'd0, 1'b0);
        check("err_one_cycle",    {31'd0, err_o}, 32'd0);
        tick(2'd1, 1'b0);
        tick(2'd2, 1'b0);
        tick(2'd3, 1'b0);
        check("relock_not_yet",   {31'd0, locked_o}, 32'd0);
        tick(2'd0, 1'b0);
        check("relock",           {31'd0, locked_o}, 32'd1);
        check("wrap_unlocked_ign",{24'd0, wrap_count_o}, 32'd4);

        // Four more errors, each followed by a relock.
        for (int e = 0; e < 4; e++) begin
            tick(cur + 2'd2, 1'b0);
            check("err_inject", {31'd0, err_o}, 32'd1);
            tick(cur + 2'd1, 1'b0);
            for (int j = 0; j < 4; j++) tick(cur + 2'd1, 1'b0);
            check("relock_loop", {31'd0, locked_o}, 32'd1);
        end
        check("errcnt_5",         {28'd0, err_count_o}, 32'd5);
        check("errcnt_saturate",  {30'd0, s_err_count_o}, 32'd3);
        check("wrap_kept",        {24'd0, wrap_count_o}, 32'd4);
`ifdef COUNT_CHECKER_CAPTURE_EN
        check("cap_no_overwrite", {28'd0, cap_exp_o, cap_act_o}, 32'hB);
`endif

        // Clear on the same edge as a bad step.
        tick(cur + 2'd2, 1'b1);
        check("clr_no_err",       {31'd0, err_o}, 32'd0);
        check("clr_errcnt",       {28'd0, err_count_o}, 32'd0);
        check("clr_wrap",         {24'd0, wrap_count_o}, 32'd0);
        check("clr_unlocked",     {31'd0, locked_o}, 32'd0);
        check("clr_sat_errcnt",   {30'd0, s_err_count_o}, 32'd0);
`ifdef COUNT_CHECKER_CAPTURE_EN
        check("clr_cap_valid",    {31'd0, cap_valid_o}, 32'd0);
`endif
        for (int j = 0; j < 4; j++) tick(cur + 2'd1, 1'b0);
        check("clr_reprime",      {31'd0, locked_o}, 32'd0);
        tick(cur + 2'd1, 1'b0);
        check("clr_relock",       {31'd0, locked_o}, 32'd1);
        for (int j = 0; j < 4; j++) tick(cur + 2'd1, 1'b0);
        check("wrap_after_clr",   {24'd0, wrap_count_o}, 32'd1);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_locked",     {31'd0, locked_o}, 32'd0);
        check("async_wrap",       {24'd0, wrap_count_o}, 32'd0);
        check("async_err",        {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant count never locks and is not an error.
        for (int j = 0; j < 8; j++) tick(cur, 1'b0);
        check("hold_no_lock",     {31'd0, locked_o}, 32'd0);
        check("hold_no_errcnt",   {28'd0, err_count_o}, 32'd0);
        for (int j = 0; j < 4; j++) tick(cur + 2'd1, 1'b0);
        check("lock_after_hold",  {31'd0, locked_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
